// File: rtl/agex_mc_stage.sv
// agex_mc_stage - execute stage: single-cycle ALU/branch unit plus an iterative radix-2 multiply/divide unit.
module agex_mc_stage #(
  parameter int DBITS = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [DBITS-1:0] src1,
  input  logic [DBITS-1:0] src2,
  input  logic [DBITS-1:0] imm,
  input  logic [DBITS-1:0] pc,
  input  logic             use_imm,
  input  logic [REGW-1:0]  dest,
  input  logic             flush,
  output logic             out_valid,
  output logic [DBITS-1:0] out_result,
  output logic [REGW-1:0]  out_dest,
  output logic             br_valid,
  output logic [DBITS-1:0] br_target,
  output logic             stall_de
);

  localparam int SHW = $clog2(DBITS);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [1:0]       mdu_fn;
  logic [REGW-1:0]  mdu_dest;
  logic [DBITS-1:0] acc_hi, acc_lo, opnd;

  logic             accept, is_mdu, alu_bv, alu_bt_upd;
  logic [DBITS-1:0] opb, alu_res, alu_bt;
  logic [SHW-1:0]   shamt;
  logic [DBITS:0]   mul_sum, div_sh;
  logic [DBITS-1:0] div_diff;
  logic             div_ge;

  assign in_ready = (state == IDLE);
  assign stall_de = in_valid & ~in_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    opb        = (use_imm && op <= 5'd9) ? imm : src2;
    shamt      = opb[SHW-1:0];
    alu_res    = '0;
    alu_bv     = 1'b0;
    alu_bt     = pc + imm;
    alu_bt_upd = 1'b0;
    is_mdu     = (op >= 5'd16) && (op <= 5'd19);
    case (op)
      5'd0:  alu_res = src1 + opb;
      5'd1:  alu_res = src1 - opb;
      5'd2:  alu_res = src1 & opb;
      5'd3:  alu_res = src1 | opb;
      5'd4:  alu_res = src1 ^ opb;
      5'd5:  alu_res = src1 << shamt;
      5'd6:  alu_res = src1 >> shamt;
      5'd7:  alu_res = DBITS'($signed(src1) >>> shamt);
      5'd8:  alu_res = {{(DBITS-1){1'b0}}, $signed(src1) < $signed(opb)};
      5'd9:  alu_res = {{(DBITS-1){1'b0}}, src1 < opb};
      5'd10: begin alu_bv = (src1 == src2);                   alu_bt_upd = 1'b1; end
      5'd11: begin alu_bv = (src1 != src2);                   alu_bt_upd = 1'b1; end
      5'd12: begin alu_bv = ($signed(src1) <  $signed(src2)); alu_bt_upd = 1'b1; end
      5'd13: begin alu_bv = ($signed(src1) >= $signed(src2)); alu_bt_upd = 1'b1; end
      5'd14: begin alu_bv = (src1 <  src2);                   alu_bt_upd = 1'b1; end
      5'd15: begin alu_bv = (src1 >= src2);                   alu_bt_upd = 1'b1; end
      5'd20: begin
        alu_res    = pc + DBITS'(4);
        alu_bv     = 1'b1;
        alu_bt_upd = 1'b1;
      end
      5'd21: begin
        alu_res    = pc + DBITS'(4);
        alu_bt     = (src1 + imm) & ~DBITS'(1);
        alu_bv     = 1'b1;
        alu_bt_upd = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  // One shared shift register pair: multiply shifts the product right, divide shifts the dividend left.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {acc_hi, acc_lo[DBITS-1]};
    div_ge   = div_sh >= {1'b0, opnd};
    div_diff = div_sh[DBITS-1:0] - opnd;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && is_mdu) state_n = BUSY;
      BUSY:    if (cnt == CW'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      mdu_fn   <= '0;
      mdu_dest <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept && is_mdu) begin
      cnt      <= CW'(DBITS);
      mdu_fn   <= op[1:0];
      mdu_dest <= dest;
      acc_hi   <= '0;
      acc_lo   <= op[1] ? src1 : src2;
      opnd     <= op[1] ? src2 : src1;
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
      if (mdu_fn[1]) begin
        acc_hi <= div_ge ? div_diff : div_sh[DBITS-1:0];
        acc_lo <= {acc_lo[DBITS-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[DBITS:1];
        acc_lo <= {mul_sum[0], acc_lo[DBITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dest   <= '0;
      br_valid   <= 1'b0;
      br_target  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      br_valid  <= 1'b0;
    end else if (accept && !is_mdu) begin
      out_valid  <= 1'b1;
      out_result <= alu_res;
      out_dest   <= dest;
      br_valid   <= alu_bv;
      if (alu_bt_upd) br_target <= alu_bt;
    end else if (state == DONE) begin
      out_valid  <= 1'b1;
      out_result <= mdu_fn[0] ? acc_hi : acc_lo;
      out_dest   <= mdu_dest;
      br_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      br_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_agex_mc_stage.sv
// tb/tb_agex_mc_stage.sv - randomized and directed bench for agex_mc_stage against a behavioural model.
module tb_agex_mc_stage;

  localparam int DBITS = 32;
  localparam int REGW  = 5;
  localparam logic [4:0] ADD = 5'd0, BLT = 5'd12, BLTU = 5'd14, MUL = 5'd16,
                         MULHU = 5'd17, DIVU = 5'd18, REMU = 5'd19, NOP = 5'd22;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, use_imm = 1'b0, flush = 1'b0;
  logic [4:0] op = 5'd0;
  logic [31:0] src1 = '0, src2 = '0, imm = '0, pc = '0;
  logic [4:0] dest = '0;
  logic in_ready, out_valid, br_valid, stall_de;
  logic [31:0] out_result, br_target;
  logic [4:0] out_dest;

  int n_tests = 0, n_fail = 0;

  agex_mc_stage #(.DBITS(DBITS), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .imm(imm), .pc(pc), .use_imm(use_imm), .dest(dest),
    .flush(flush), .out_valid(out_valid), .out_result(out_result), .out_dest(out_dest),
    .br_valid(br_valid), .br_target(br_target), .stall_de(stall_de)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour straight from the op table, using plain integer arithmetic.
  function automatic void ref_op(input logic [4:0] o, input logic [31:0] a, b, im, p,
                                 input logic ui, output logic [31:0] res, output logic bv,
                                 output logic [31:0] bt);
    logic [31:0] ob;
    logic [63:0] prod;
    ob   = (ui && o <= 9) ? im : b;
    prod = {32'd0, a} * {32'd0, b};
    res  = 0;
    bv   = 0;
    bt   = p + im;
    case (o)
      0:  res = a + ob;
      1:  res = a - ob;
      2:  res = a & ob;
      3:  res = a | ob;
      4:  res = a ^ ob;
      5:  res = a << ob[4:0];
      6:  res = a >> ob[4:0];
      7:  res = 32'(int'(a) >>> ob[4:0]);
      8:  res = (int'(a) < int'(ob)) ? 1 : 0;
      9:  res = (a < ob) ? 1 : 0;
      10: bv = (a == b);
      11: bv = (a != b);
      12: bv = (int'(a) < int'(b));
      13: bv = (int'(a) >= int'(b));
      14: bv = (a < b);
      15: bv = (a >= b);
      16: res = prod[31:0];
      17: res = prod[63:32];
      18: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      19: res = (b == 0) ? a : a % b;
      20: begin res = p + 4; bv = 1; end
      21: begin res = p + 4; bv = 1; bt = (a + im) & ~32'd1; end
      default: res = 0;
    endcase
  endfunction

  logic e_ov, e_bv;
  logic [31:0] e_res, e_bt, m_res;
  logic [4:0] e_dest, m_dest;
  int m_left;

  // m_left counts cycles until the pending multiply/divide result appears; zero means ready.
  always @(posedge clk or posedge reset) begin
    logic [31:0] r, t;
    logic b;
    if (reset) begin
      e_ov = 0; e_bv = 0; e_res = 0; e_bt = 0; e_dest = 0; m_left = 0;
    end else begin
      e_ov = 0; e_bv = 0;
      if (flush) begin
        m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin e_ov = 1; e_res = m_res; e_dest = m_dest; end
      end else if (in_valid) begin
        ref_op(op, src1, src2, imm, pc, use_imm, r, b, t);
        if (op >= 16 && op <= 19) begin
          m_left = DBITS + 1; m_res = r; m_dest = dest;
        end else begin
          e_ov = 1; e_res = r; e_dest = dest; e_bv = b;
          if ((op >= 10 && op <= 15) || op == 20 || op == 21) e_bt = t;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("out_valid", out_valid, e_ov);
      chk("br_valid", br_valid, e_bv);
      if (e_ov) begin
        chk("out_result", out_result, e_res);
        chk("out_dest", out_dest, e_dest);
      end
      if (e_bv) chk("br_target", br_target, e_bt);
      if (m_left != 1) begin
        chk("in_ready", in_ready, m_left == 0);
        chk("stall_de", stall_de, in_valid && m_left != 0);
      end
    end
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] a, b, im, p,
                       input logic ui, input logic [4:0] d);
    @(negedge clk);
    op = o; src1 = a; src2 = b; imm = im; pc = p; use_imm = ui; dest = d; in_valid = 1;
    @(posedge clk);
    #2 in_valid = 0;
  endtask

  task automatic mdu_run(input logic [4:0] o, input logic [31:0] a, b,
                         output int lat, output logic [31:0] res);
    issue(o, a, b, 0, 0, 0, 5'd9);
    in_valid = 1; op = NOP;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat < 32) begin
        chk("mdu_in_ready_low", in_ready, 0);
        chk("mdu_stall_de", stall_de, 1);
      end
      @(posedge clk);
      #2 lat++;
    end
    in_valid = 0;
    res = out_result;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt;
    logic [31:0] res;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_br_valid", br_valid, 0);
    chk("rst_br_target", br_target, 0);
    @(negedge clk) reset = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall_de", stall_de, 0);

    issue(ADD, 5, 7, 0, 0, 0, 5'd3);
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 12);
    chk("add_br_valid", br_valid, 0);

    issue(BLT, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 0, 5'd4);
    chk("blt_taken", br_valid, 1);
    chk("blt_target", br_target, 32'h120);
    issue(BLTU, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 0, 5'd4);
    chk("bltu_not_taken", br_valid, 0);

    mdu_run(MUL, 32'h10000, 32'h10000, lat, res);
    chk("mul_latency", lat, 33);
    chk("mul_result", res, 0);
    mdu_run(MULHU, 32'h10000, 32'h10000, lat, res);
    chk("mulhu_result", res, 1);
    mdu_run(DIVU, 100, 0, lat, res);
    chk("divu_by_zero", res, 32'hFFFF_FFFF);
    mdu_run(REMU, 100, 7, lat, res);
    chk("remu_result", res, 2);
    mdu_run(DIVU, 100, 7, lat, res);
    chk("divu_result", res, 14);
    chk("divu_latency", lat, 33);

    issue(DIVU, 100, 7, 0, 0, 0, 5'd6);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1;
    @(posedge clk);
    #2 flush = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    cnt = 0;
    repeat (40) begin @(posedge clk); #2 if (out_valid) cnt++; end
    chk("flush_no_result", cnt, 0);
    issue(ADD, 1, 2, 0, 0, 0, 5'd7);
    chk("post_flush_add", out_result, 3);
    chk("post_flush_valid", out_valid, 1);

    issue(MUL, 3, 5, 0, 0, 0, 5'd11);
    repeat (5) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_result", out_result, 0);
    chk("arst_out_dest", out_dest, 0);
    chk("arst_br_valid", br_valid, 0);
    chk("arst_br_target", br_target, 0);
    @(negedge clk) reset = 0;
    #1 chk("arst_in_ready", in_ready, 1);
    cnt = 0;
    repeat (40) begin @(posedge clk); #2 if (out_valid) cnt++; end
    chk("arst_discarded", cnt, 0);

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      op = 5'($urandom_range(0, 31));
      src1 = rnd_val(); src2 = rnd_val(); imm = rnd_val(); pc = $urandom;
      use_imm = 1'($urandom_range(0, 1));
      dest = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    in_valid = 0; flush = 0;
    repeat (40) @(posedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/agex_mc_stage.md
AGEX_MC_STAGE -- requirements
Module: agex_mc_stage

Interface
REQ-001 SHALL have parameter DBITS, default 32, meaning datapath/PC width; legal values are powers of two, 8 to 64.
REQ-002 SHALL have parameter REGW, default 5, meaning destination register index width.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  meaning a decoded instruction is presented.
REQ-006 SHALL have port in_ready  out  1  meaning the stage accepts the instruction this cycle.
REQ-007 SHALL have port op  in  5  meaning operation code per REQ-015.
REQ-008 SHALL have port src1, src2, imm, pc  in  DBITS each  meaning operands, immediate and instruction PC.
REQ-009 SHALL have port use_imm  in  1  meaning operand B is imm, else src2 (ALU ops only).
REQ-010 SHALL have port dest  in  REGW  meaning destination register index.
REQ-011 SHALL have port flush  in  1  meaning kill any in-flight operation and the output latch.
REQ-012 SHALL have ports out_valid 1, out_result DBITS, out_dest REGW  out  meaning the registered AGEX latch.
REQ-013 SHALL have ports br_valid 1, br_target DBITS  out  meaning a registered redirect to FE.
REQ-014 SHALL have port stall_de  out  1  meaning DE must hold its latch; equals in_valid AND NOT in_ready.

Function
REQ-015 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 16 MUL (low half), 17 MULHU, 18 DIVU, 19 REMU, 20 JAL, 21 JALR; 22-31 are NOP.
REQ-016 Arithmetic SHALL wrap modulo 2^DBITS; shift amount = low log2(DBITS) bits of operand B; SLT/BLT/BGE signed, others unsigned.
REQ-017 Ops 0-15 and 20-22+ SHALL be single-cycle: accepted at edge N, out_valid=1 with result after edge N (latency 1), in_ready stays 1.
REQ-018 Branch ops SHALL produce out_result=0, br_target=pc+imm, br_valid=condition; JAL SHALL produce out_result=pc+4, br_target=pc+imm, br_valid=1; JALR SHALL produce br_target=(src1+imm) with bit0 cleared, out_result=pc+4, br_valid=1.
REQ-019 NOP SHALL produce out_valid=1, out_result=0, br_valid=0.
REQ-020 Ops 16-19 SHALL use one iterative radix-2 unit; FSM states IDLE, BUSY, DONE.
REQ-021 IDLE->BUSY on accept of an MDU op; counter loads DBITS; in_ready=0 in BUSY and DONE.
REQ-022 BUSY decrements once per cycle; at count 1 transitions to DONE; DONE writes the output latch (out_valid=1) and returns to IDLE with in_ready=1 the same edge.
REQ-023 MDU latency SHALL be exactly DBITS+1 cycles from accept edge to out_valid (33 for DBITS=32).
REQ-024 DIVU by zero SHALL return all ones; REMU by zero SHALL return the dividend; no exception.
REQ-025 out_valid and br_valid SHALL be single-cycle pulses per instruction; with no accept and no MDU completion, out_valid=0, br_valid=0.
REQ-026 flush SHALL override everything: on the edge where flush=1, FSM to IDLE, out_valid=0, br_valid=0, the input is not accepted; in_ready=1 the next cycle.
REQ-027 in_ready SHALL be combinational from FSM state only (not from in_valid).
REQ-028 out_dest SHALL hold the dest captured at accept for the instruction reported.

Reset
REQ-029 On reset assertion, asynchronously: FSM=IDLE, counter=0, out_valid=0, out_result=0, out_dest=0, br_valid=0, br_target=0; in_ready=1 and stall_de=0 once reset is low.
REQ-030 Reset mid-MDU operation SHALL discard it; no out_valid for it after release.

Verification
REQ-031 ADD src1=5, src2=7, use_imm=0 -> next cycle out_valid=1, out_result=12, br_valid=0.
REQ-032 BLT src1=0xFFFFFFFF, src2=1, pc=0x100, imm=0x20 -> br_valid=1, br_target=0x120; BLTU same operands -> br_valid=0.
REQ-033 MUL 0x10000 x 0x10000 (DBITS=32) -> in_ready=0 and stall_de=1 for 32 cycles, out_result=0 at accept+33; MULHU same -> 1.
REQ-034 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/7 -> 2; DIVU 100/7 -> 14.
REQ-035 flush at cycle 10 of a DIVU -> no out_valid, in_ready=1 next cycle, following ADD completes with latency 1.
REQ-036 Async reset pulse mid-cycle during BUSY -> all outputs zero immediately, in_ready=1 after release.
